test_runner: RTL

- Downstream consumer of a self-checking test bench's `fail`/`finish` outputs.
- Generates the bench's reset sequence, then watches the bench until it finishes, fails or times out.
- Reports one registered verdict: `done`, `pass`, `timed_out` and a run-cycle count.
- Sits between a test bench and the simulation/CI top, so every test bench is driven and judged the same way.

---
 rtl/test_runner.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/test_runner.sv
// test_runner: drives a self-checking bench through reset, watches its
// fail/finish outputs until it finishes or hangs, and holds one registered
// verdict (done/pass/timed_out plus a saturating run-cycle count).
module test_runner #(
  parameter int RESET_CYCLES = 4,
  parameter int TIMEOUT      = 1000,
  parameter int DRAIN_CYCLES = 2,
  parameter int CW           = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          dut_fail,
  input  logic          dut_finish,
  output logic          dut_reset,
  output logic          done,
  output logic          pass,
  output logic          timed_out,
  output logic [CW-1:0] cycles
);

  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [RCW-1:0] RST_LAST   = RCW'(RESET_CYCLES - 1);
  localparam logic [RCW-1:0] RST_ZERO   = RCW'(0);
  localparam logic [RCW-1:0] RST_ONE    = RCW'(1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
  localparam logic [DCW-1:0] DRAIN_ZERO = DCW'(0);
  localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);
  localparam logic [CW-1:0]  TO_LAST    = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CYC_ZERO   = CW'(0);
  localparam logic [CW-1:0]  CYC_ONE    = CW'(1);
  localparam logic [CW-1:0]  CYC_MAX    = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e         state_q;
  logic [RCW-1:0] rst_cnt_q;
  logic [DCW-1:0] drain_cnt_q;
  logic           fail_seen_q;
  logic           dut_reset_q;
  logic           done_q;
  logic           pass_q;
  logic           timed_out_q;
  logic [CW-1:0]  cycles_q;

  logic [CW-1:0]  cycles_d;
  logic           fail_any_d;

  // Saturating run-cycle increment and the fail flag including this cycle's sample.
  always_comb begin
    cycles_d   = cycles_q;
    fail_any_d = fail_seen_q | dut_fail;
    if (cycles_q != CYC_MAX) begin
      cycles_d = cycles_q + CYC_ONE;
    end else begin
      cycles_d = cycles_q;
    end
  end

  // Run-control FSM; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RST;
      rst_cnt_q   <= RST_ZERO;
      drain_cnt_q <= DRAIN_ZERO;
      fail_seen_q <= 1'b0;
      dut_reset_q <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timed_out_q <= 1'b0;
      cycles_q    <= CYC_ZERO;
    end else begin
      case (state_q)
        ST_RST: begin
          dut_reset_q <= 1'b1;
          if (rst_cnt_q == RST_LAST) begin
            state_q     <= ST_RUN;
            dut_reset_q <= 1'b0;
            rst_cnt_q   <= RST_ZERO;
          end else begin
            rst_cnt_q <= rst_cnt_q + RST_ONE;
          end
        end
        ST_RUN: begin
          cycles_q    <= cycles_d;
          fail_seen_q <= fail_any_d;
          // A finish in the same cycle as the timeout wins.
          if (dut_finish) begin
            if (DRAIN_CYCLES == 0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= ~fail_any_d;
            end else begin
              state_q     <= ST_DRAIN;
              drain_cnt_q <= DRAIN_ZERO;
            end
          end else if (cycles_q == TO_LAST) begin
            state_q     <= ST_DONE;
            done_q      <= 1'b1;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          // Late fails are still captured; the cycle count stays frozen.
          fail_seen_q <= fail_any_d;
          if (drain_cnt_q == DRAIN_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            pass_q  <= ~fail_any_d & ~timed_out_q;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRAIN_ONE;
          end
        end
        ST_DONE: begin
          // Verdict holds and the bench stays out of reset until restarted.
          if (start) begin
            state_q     <= ST_RST;
            rst_cnt_q   <= RST_ZERO;
            drain_cnt_q <= DRAIN_ZERO;
            fail_seen_q <= 1'b0;
            dut_reset_q <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            cycles_q    <= CYC_ZERO;
          end
        end
        default: begin
          state_q     <= ST_RST;
          rst_cnt_q   <= RST_ZERO;
          drain_cnt_q <= DRAIN_ZERO;
          fail_seen_q <= 1'b0;
          dut_reset_q <= 1'b1;
          done_q      <= 1'b0;
          pass_q      <= 1'b0;
          timed_out_q <= 1'b0;
          cycles_q    <= CYC_ZERO;
        end
      endcase
    end
  end

  assign dut_reset = dut_reset_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timed_out = timed_out_q;
  assign cycles    = cycles_q;

endmodule
